// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multi-cycle ARM32 control FSM:
//   - state_t          : controller state encoding
//   - opcode constants : NOP / HALT encodings, data-processing forms, CMP op
//   - COND_*           : ARM condition-field encodings
//   - select constants : meaning of each datapath mux select value
//   - class decoders   : is_data, is_reg_shifted, is_branch, is_load,
//                        is_store, writes_rd, is_nop, is_halt, is_reserved
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_READ_S,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_WB_BASE,
        ST_HALT
    } state_t;

    localparam logic [6:0] OP_NOP  = 7'b0000000;
    localparam logic [6:0] OP_HALT = 7'b0000001;

    // Data-processing forms live in opcode[6:4], the ALU op in opcode[2:0]
    localparam logic [2:0] DP_IMM       = 3'b000;
    localparam logic [2:0] DP_REG       = 3'b001;
    localparam logic [2:0] DP_REG_SHIFT = 3'b011;
    localparam logic [2:0] ALU_CMP      = 3'b010;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic SEL_PC_PLUS4 = 1'b0;
    localparam logic SEL_PC_ALU   = 1'b1;
    localparam logic MEM_ADDR_PC  = 1'b0;
    localparam logic MEM_ADDR_AR  = 1'b1;
    localparam logic WB_SEL_C     = 1'b0;
    localparam logic WB_SEL_MEM   = 1'b1;
    localparam logic WB_DST_RD    = 1'b0;
    localparam logic WB_DST_RN    = 1'b1;
    localparam logic SEL_ADDR_C   = 1'b0;
    localparam logic SEL_ADDR_A   = 1'b1;

    function automatic logic is_data(input logic [6:0] op);
        return (op[6] == 1'b0) && (op[3] == 1'b1) &&
               ((op[6:4] == DP_IMM) || (op[6:4] == DP_REG) ||
                (op[6:4] == DP_REG_SHIFT));
    endfunction

    function automatic logic is_reg_shifted(input logic [6:0] op);
        return is_data(op) && (op[6:4] == DP_REG_SHIFT);
    endfunction

    function automatic logic is_branch(input logic [6:0] op);
        return op[6:3] == 4'b1000;
    endfunction

    // Two load encodings: PC-relative literal and the general base form
    function automatic logic is_load(input logic [6:0] op);
        return (op[6:3] == 4'b1001) || (op[6:4] == 3'b110);
    endfunction

    function automatic logic is_store(input logic [6:0] op);
        return op[6:4] == 3'b111;
    endfunction

    // CMP only updates flags, so it never gets a register writeback
    function automatic logic writes_rd(input logic [6:0] op);
        return is_data(op) && (op[2:0] != ALU_CMP);
    endfunction

    function automatic logic is_nop(input logic [6:0] op);
        return op == OP_NOP;
    endfunction

    function automatic logic is_halt(input logic [6:0] op);
        return op == OP_HALT;
    endfunction

    function automatic logic is_reserved(input logic [6:0] op);
        return !(is_nop(op) || is_halt(op) || is_data(op) ||
                 is_branch(op) || is_load(op) || is_store(op));
    endfunction

endpackage

// File: rtl/cpu_controller_cond_eval.sv
// ----------------------------------------------------------------------------
// cond_eval
// Combinational ARM condition-code check.
//   cond   [3:0] in  : instruction condition field
//   status [3:0] in  : current flags, ordered N,Z,C,V
//   pass         out : 1 when the instruction is allowed to execute
// Both AL and the 1111 encoding are treated as always-pass.
// ----------------------------------------------------------------------------
module cond_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign {n, z, c, v} = status;

    // Standard ARM EQ..AL truth table over the NZCV flags
    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// ----------------------------------------------------------------------------
// cpu_controller
// Multi-cycle control FSM for the ARM32 datapath. One instruction in flight;
// fetch and data accesses use a req/ack handshake with variable latency.
// Inputs : clk, rst_n (sync, active-low), opcode/cond/en_status/P/W from the
//          instruction decoder, status (NZCV), mem_ack.
// Outputs: mem_req, mem_we, mem_addr_sel, load_ir, load_pc, sel_pc,
//          en_A, en_B, en_S, en_C, en_status_reg, wb_en, wb_sel, wb_dst_sel,
//          sel_addr, halted, illegal.
// ----------------------------------------------------------------------------
module cpu_controller
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [3:0] cond,
    input  logic       en_status,
    input  logic       P,
    input  logic       W,
    input  logic [3:0] status,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       sel_pc,
    output logic       en_A,
    output logic       en_B,
    output logic       en_S,
    output logic       en_C,
    output logic       en_status_reg,
    output logic       wb_en,
    output logic       wb_sel,
    output logic       wb_dst_sel,
    output logic       sel_addr,
    output logic       halted,
    output logic       illegal
);

    state_t state;
    logic   cond_pass;
    logic   base_wb;

    cond_eval u_cond_eval (
        .cond   (cond),
        .status (status),
        .pass   (cond_pass)
    );

    // Post-index (P=0) always updates the base; pre-index only when W is set
    assign base_wb = W || !P;

    // State register and next-state selection. Memory states wait for
    // mem_ack; a low rst_n parks the FSM in RESET from any state, which
    // abandons an in-flight access without any writeback.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RESET;
        end else begin
            case (state)
                ST_RESET:  state <= ST_FETCH;
                ST_FETCH:  if (mem_ack) state <= ST_DECODE;
                ST_DECODE: state <= is_reg_shifted(opcode) ? ST_READ_S : ST_EXEC;
                ST_READ_S: state <= ST_EXEC;
                ST_EXEC: begin
                    if (!cond_pass)
                        state <= ST_FETCH;
                    else if (is_data(opcode))
                        state <= writes_rd(opcode) ? ST_WB : ST_FETCH;
                    else if (is_load(opcode) || is_store(opcode))
                        state <= ST_MEM;
                    else if (is_halt(opcode))
                        state <= ST_HALT;
                    else
                        state <= ST_FETCH;
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (is_load(opcode))
                            state <= ST_WB;
                        else
                            state <= base_wb ? ST_WB_BASE : ST_FETCH;
                    end
                end
                ST_WB:      state <= (is_load(opcode) && base_wb) ? ST_WB_BASE : ST_FETCH;
                ST_WB_BASE: state <= ST_FETCH;
                ST_HALT:    state <= ST_HALT;
                default:    state <= ST_RESET;
            endcase
        end
    end

    // Output decode from the current state and the class of the held
    // instruction. Only the fetch strobes look at mem_ack directly so the IR
    // and PC capture in the same cycle the memory returns the word.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = MEM_ADDR_PC;
        load_ir       = 1'b0;
        load_pc       = 1'b0;
        sel_pc        = SEL_PC_PLUS4;
        en_A          = 1'b0;
        en_B          = 1'b0;
        en_S          = 1'b0;
        en_C          = 1'b0;
        en_status_reg = 1'b0;
        wb_en         = 1'b0;
        wb_sel        = WB_SEL_C;
        wb_dst_sel    = WB_DST_RD;
        sel_addr      = SEL_ADDR_C;
        halted        = 1'b0;
        illegal       = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req      = 1'b1;
                mem_addr_sel = MEM_ADDR_PC;
                if (mem_ack) begin
                    load_ir = 1'b1;
                    load_pc = 1'b1;
                    sel_pc  = SEL_PC_PLUS4;
                end
            end
            ST_DECODE: begin
                en_A = 1'b1;
                en_B = 1'b1;
            end
            ST_READ_S: en_S = 1'b1;
            ST_EXEC: begin
                illegal = is_reserved(opcode);
                if (cond_pass) begin
                    if (is_data(opcode)) begin
                        en_C          = 1'b1;
                        en_status_reg = en_status;
                    end else if (is_branch(opcode)) begin
                        load_pc = 1'b1;
                        sel_pc  = SEL_PC_ALU;
                    end else if (is_load(opcode) || is_store(opcode)) begin
                        en_C = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = MEM_ADDR_AR;
                sel_addr     = P ? SEL_ADDR_C : SEL_ADDR_A;
                mem_we       = is_store(opcode);
            end
            ST_WB: begin
                wb_en      = 1'b1;
                wb_sel     = is_load(opcode) ? WB_SEL_MEM : WB_SEL_C;
                wb_dst_sel = WB_DST_RD;
            end
            ST_WB_BASE: begin
                wb_en      = 1'b1;
                wb_sel     = WB_SEL_C;
                wb_dst_sel = WB_DST_RN;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
